// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the memory window bridge.
// Contents: AXI response encodings and the state enums of the error responder FSMs.
package axi_bridge_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic {
      RD_IDLE,
      RD_ERR
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_DRAIN,
      WR_RESP
   } wr_state_e;

endpackage

// File: rtl/mem_axi_window_bridge_if.sv
// AXI4 bus bundle used on both sides of the window bridge.
// Contains the AR, AW, W, R and B channels.
// Modports:
//   master - drives address, write data and response readies.
//   slave  - drives address/data readies and the R/B responses.
interface mem_axi_window_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 6
);
   logic                ar_valid, ar_ready, ar_lock;
   logic [ADDR_W-1:0]   ar_addr;
   logic [7:0]          ar_len;
   logic [2:0]          ar_size, ar_prot;
   logic [1:0]          ar_burst;
   logic [ID_W-1:0]     ar_id;
   logic [3:0]          ar_cache, ar_qos;

   logic                aw_valid, aw_ready, aw_lock;
   logic [ADDR_W-1:0]   aw_addr;
   logic [7:0]          aw_len;
   logic [2:0]          aw_size, aw_prot;
   logic [1:0]          aw_burst;
   logic [ID_W-1:0]     aw_id;
   logic [3:0]          aw_cache, aw_qos;

   logic                w_valid, w_ready, w_last;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;

   logic                r_valid, r_ready, r_last;
   logic [ID_W-1:0]     r_id;
   logic [DATA_W-1:0]   r_data;
   logic [1:0]          r_resp;

   logic                b_valid, b_ready;
   logic [ID_W-1:0]     b_id;
   logic [1:0]          b_resp;

   modport master (
      output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_lock, ar_cache, ar_prot, ar_qos,
      input  ar_ready,
      output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_lock, aw_cache, aw_prot, aw_qos,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  r_valid, r_id, r_data, r_resp, r_last,
      output r_ready,
      input  b_valid, b_id, b_resp,
      output b_ready
   );

   modport slave (
      input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_lock, ar_cache, ar_prot, ar_qos,
      output ar_ready,
      input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_lock, aw_cache, aw_prot, aw_qos,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output r_valid, r_id, r_data, r_resp, r_last,
      input  r_ready,
      output b_valid, b_id, b_resp,
      input  b_ready
   );
endinterface

// File: rtl/axi_err_responder.sv
// DECERR responder for bursts that fall outside the memory window.
// Read side : rd_start captures len/id; then len+1 R beats are emitted, with last on the final beat.
// Write side: wr_start captures id; W beats are drained until last, then one B beat is emitted.
// Ports: clock, reset_n (sync, active low); rd_* / r_* read engine; wr_* / w_* / b_* write engine.
//        rd_idle and wr_idle let the top gate new address acceptance.
module axi_err_responder
   import axi_bridge_pkg::*;
#(
   parameter int ID_W = 6
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            rd_start,
   input  logic [7:0]      rd_len,
   input  logic [ID_W-1:0] rd_id,
   input  logic            r_ready,
   output logic            r_valid,
   output logic            r_last,
   output logic [ID_W-1:0] r_id,
   output logic            rd_idle,
   input  logic            wr_start,
   input  logic [ID_W-1:0] wr_id,
   input  logic            w_valid,
   input  logic            w_last,
   output logic            w_drain,
   input  logic            b_ready,
   output logic            b_valid,
   output logic [ID_W-1:0] b_id,
   output logic            wr_idle
);
   rd_state_e       rd_state_q, rd_state_d;
   wr_state_e       wr_state_q, wr_state_d;
   logic [7:0]      len_q, len_d, beat_q, beat_d;
   logic [ID_W-1:0] rid_q, rid_d, bid_q, bid_d;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_state_q <= RD_IDLE;
         wr_state_q <= WR_IDLE;
         len_q      <= '0;
         beat_q     <= '0;
         rid_q      <= '0;
         bid_q      <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         rid_q      <= rid_d;
         bid_q      <= bid_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      len_d      = len_q;
      beat_d     = beat_q;
      rid_d      = rid_q;
      r_valid    = 1'b0;
      r_last     = 1'b0;
      rd_idle    = 1'b0;
      unique case (rd_state_q)
         RD_IDLE: begin
            rd_idle = 1'b1;
            if (rd_start) begin
               rd_state_d = RD_ERR;
               len_d      = rd_len;
               beat_d     = '0;
               rid_d      = rd_id;
            end
         end
         RD_ERR: begin
            r_valid = 1'b1;
            r_last  = (beat_q == len_q);
            if (r_ready) begin
               if (beat_q == len_q) rd_state_d = RD_IDLE;
               else                 beat_d     = beat_q + 8'd1;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      bid_d      = bid_q;
      w_drain    = 1'b0;
      b_valid    = 1'b0;
      wr_idle    = 1'b0;
      unique case (wr_state_q)
         WR_IDLE: begin
            wr_idle = 1'b1;
            if (wr_start) begin
               wr_state_d = WR_DRAIN;
               bid_d      = wr_id;
            end
         end
         // w_ready is forced high while draining, so valid alone is a handshake
         WR_DRAIN: begin
            w_drain = 1'b1;
            if (w_valid && w_last) wr_state_d = WR_RESP;
         end
         WR_RESP: begin
            b_valid = 1'b1;
            if (b_ready) wr_state_d = WR_IDLE;
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   assign r_id = rid_q;
   assign b_id = bid_q;

endmodule

// File: rtl/mem_axi_window_bridge.sv
// AXI4 bridge from a core-side address window onto a DRAM window at WIN_BASE.
// In-window bursts are forwarded with zero latency and the address is rebased.
// Out-of-window bursts are answered locally with DECERR by axi_err_responder.
// Ports: clock, reset_n (sync, active low); s = core-side slave bus; m = HP-port master bus;
//        err_count (saturating count of rejected bursts); rd_out/wr_out (outstanding forwarded bursts).
module mem_axi_window_bridge
   import axi_bridge_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 64,
   parameter int              ID_W     = 6,
   parameter int              WIN_BITS = 28,
   parameter logic [ADDR_W-1:0] WIN_BASE = 32'h1000_0000,
   parameter int              MAX_OUT  = 8
) (
   input  logic                         clock,
   input  logic                         reset_n,
   mem_axi_window_bridge_if.slave       s,
   mem_axi_window_bridge_if.master      m,
   output logic [15:0]                  err_count,
   output logic [$clog2(MAX_OUT+1)-1:0] rd_out,
   output logic [$clog2(MAX_OUT+1)-1:0] wr_out
);
   localparam int CNT_W = $clog2(MAX_OUT+1);
   // Wide enough for a window offset plus the largest burst (256 beats << 7).
   localparam int SUM_W = WIN_BITS + 17;

   function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                      input logic [7:0] len, input logic [2:0] size);
      logic [SUM_W-1:0] burst_end;
      burst_end = SUM_W'(addr[WIN_BITS-1:0]) + ((SUM_W'(len) + SUM_W'(1)) << size);
      return (addr[ADDR_W-1:WIN_BITS] == '0) && (burst_end <= (SUM_W'(1) << WIN_BITS));
   endfunction

   logic [CNT_W-1:0] rd_out_q, rd_out_d, wr_out_q, wr_out_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [16:0]      err_sum;
   logic             ar_win, aw_win, rd_room, wr_room, err_ar_go, err_aw_go;
   logic             rd_inc, rd_dec, wr_inc, wr_dec;
   logic             rd_idle, wr_idle, w_drain, r_err_valid, r_err_last, b_err_valid;
   logic [ID_W-1:0]  r_err_id, b_err_id;

   assign ar_win  = in_window(s.ar_addr, s.ar_len, s.ar_size);
   assign aw_win  = in_window(s.aw_addr, s.aw_len, s.aw_size);
   assign rd_room = rd_out_q < CNT_W'(MAX_OUT);
   assign wr_room = wr_out_q < CNT_W'(MAX_OUT);

   // Error bursts wait for the forwarded ones to drain so responses never interleave.
   assign m.ar_valid = reset_n && s.ar_valid && ar_win && rd_room && rd_idle;
   assign s.ar_ready = reset_n && (ar_win ? (rd_room && rd_idle && m.ar_ready)
                                          : (rd_out_q == '0 && rd_idle));
   assign m.aw_valid = reset_n && s.aw_valid && aw_win && wr_room && wr_idle;
   assign s.aw_ready = reset_n && (aw_win ? (wr_room && wr_idle && m.aw_ready)
                                          : (wr_out_q == '0 && wr_idle));
   assign err_ar_go  = s.ar_valid && s.ar_ready && !ar_win;
   assign err_aw_go  = s.aw_valid && s.aw_ready && !aw_win;

   assign m.ar_addr  = WIN_BASE | {{(ADDR_W-WIN_BITS){1'b0}}, s.ar_addr[WIN_BITS-1:0]};
   assign m.ar_len   = s.ar_len;
   assign m.ar_size  = s.ar_size;
   assign m.ar_burst = s.ar_burst;
   assign m.ar_id    = s.ar_id;
   assign m.ar_lock  = s.ar_lock;
   assign m.ar_cache = s.ar_cache;
   assign m.ar_prot  = s.ar_prot;
   assign m.ar_qos   = s.ar_qos;
   assign m.aw_addr  = WIN_BASE | {{(ADDR_W-WIN_BITS){1'b0}}, s.aw_addr[WIN_BITS-1:0]};
   assign m.aw_len   = s.aw_len;
   assign m.aw_size  = s.aw_size;
   assign m.aw_burst = s.aw_burst;
   assign m.aw_id    = s.aw_id;
   assign m.aw_lock  = s.aw_lock;
   assign m.aw_cache = s.aw_cache;
   assign m.aw_prot  = s.aw_prot;
   assign m.aw_qos   = s.aw_qos;

   // W passes straight through except while an error burst's data is being discarded.
   assign m.w_valid  = reset_n && s.w_valid && !w_drain;
   assign s.w_ready  = reset_n && (w_drain || m.w_ready);
   assign m.w_data   = s.w_data;
   assign m.w_strb   = s.w_strb;
   assign m.w_last   = s.w_last;

   assign s.r_valid  = reset_n && (rd_idle ? m.r_valid : r_err_valid);
   assign s.r_data   = rd_idle ? m.r_data : {DATA_W{1'b0}};
   assign s.r_resp   = rd_idle ? m.r_resp : RESP_DECERR;
   assign s.r_id     = rd_idle ? m.r_id   : r_err_id;
   assign s.r_last   = rd_idle ? m.r_last : r_err_last;
   assign m.r_ready  = reset_n && rd_idle && s.r_ready;

   assign s.b_valid  = reset_n && (b_err_valid || m.b_valid);
   assign s.b_resp   = b_err_valid ? RESP_DECERR : m.b_resp;
   assign s.b_id     = b_err_valid ? b_err_id    : m.b_id;
   assign m.b_ready  = reset_n && !b_err_valid && s.b_ready;

   axi_err_responder #(.ID_W(ID_W)) u_err (
      .clock    (clock),
      .reset_n  (reset_n),
      .rd_start (err_ar_go),
      .rd_len   (s.ar_len),
      .rd_id    (s.ar_id),
      .r_ready  (s.r_ready),
      .r_valid  (r_err_valid),
      .r_last   (r_err_last),
      .r_id     (r_err_id),
      .rd_idle  (rd_idle),
      .wr_start (err_aw_go),
      .wr_id    (s.aw_id),
      .w_valid  (s.w_valid),
      .w_last   (s.w_last),
      .w_drain  (w_drain),
      .b_ready  (s.b_ready),
      .b_valid  (b_err_valid),
      .b_id     (b_err_id),
      .wr_idle  (wr_idle)
   );

   assign rd_inc = m.ar_valid && m.ar_ready;
   assign rd_dec = m.r_valid && m.r_ready && m.r_last;
   assign wr_inc = m.aw_valid && m.aw_ready;
   assign wr_dec = m.b_valid && m.b_ready;

   always_comb begin
      rd_out_d = rd_out_q;
      wr_out_d = wr_out_q;
      if (rd_inc && !rd_dec)      rd_out_d = rd_out_q + CNT_W'(1);
      else if (!rd_inc && rd_dec) rd_out_d = rd_out_q - CNT_W'(1);
      if (wr_inc && !wr_dec)      wr_out_d = wr_out_q + CNT_W'(1);
      else if (!wr_inc && wr_dec) wr_out_d = wr_out_q - CNT_W'(1);
      err_sum     = {1'b0, err_count_q} + 17'(err_ar_go) + 17'(err_aw_go);
      err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_out_q    <= '0;
         wr_out_q    <= '0;
         err_count_q <= '0;
      end else begin
         rd_out_q    <= rd_out_d;
         wr_out_q    <= wr_out_d;
         err_count_q <= err_count_d;
      end
   end

   assign rd_out    = rd_out_q;
   assign wr_out    = wr_out_q;
   assign err_count = err_count_q;

endmodule
